mem_ctrl_nport: RTL and testbench

//  Parametrised multi-port memory controller. Arbitrates NPORT word-level requests (IF fetch, MEM load/store, ...)

---
 rtl/mem_ctrl_nport_pkg.sv | 28 ++
 rtl/mem_ctrl_nport_arb.sv | 37 +++
 rtl/mem_ctrl_nport.sv | 184 ++++++++++++++++++
 tb/tb_mem_ctrl_nport.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_nport_pkg.sv
// Shared types and constants for the multi-port byte-bus memory controller.
//   mem_len_t   : request length code (byte count - 1)
//   mc_state_e  : controller FSM state encoding
//   last_cnt()  : final byte-counter value of a transfer
package mem_ctrl_nport_pkg;

  typedef logic [1:0] mem_len_t;

  localparam mem_len_t LEN_B = 2'd0;  // 1 byte
  localparam mem_len_t LEN_H = 2'd1;  // 2 bytes
  localparam mem_len_t LEN_W = 2'd3;  // 4 bytes (2'd2 yields a 3-byte access)

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_RD   = 2'd1,
    MC_WR   = 2'd2
  } mc_state_e;

  localparam int CNT_W = 3;

  // A read spends len+1 cycles issuing addresses plus two more cycles while the
  // registered address and the RAM's registered data catch up. A write needs
  // only one trailing cycle for its last byte to sit on the bus.
  function automatic logic [CNT_W-1:0] last_cnt(input mem_len_t len, input logic is_rd);
    return {1'b0, len} + (is_rd ? 3'd2 : 3'd1);
  endfunction

endpackage

// File: rtl/mem_ctrl_nport_arb.sv
// rr_arbiter_n: combinational one-hot arbiter.
//   eligible_i : per-port request mask
//   ptr_i      : round-robin start index (ignored in fixed mode)
//   mode_i     : 0 = fixed priority (lowest index), 1 = round-robin
//   grant_o    : one-hot grant, all zero when nothing is eligible
module rr_arbiter_n
  import mem_ctrl_nport_pkg::*;
#(
  parameter int NPORT = 2,
  parameter int PTR_W = 1
) (
  input  logic [NPORT-1:0] eligible_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic             mode_i,
  output logic [NPORT-1:0] grant_o
);

  logic [NPORT-1:0] hi_req;
  logic [NPORT-1:0] pick;

  // Round-robin = lowest-index-first among ports at or above the pointer,
  // falling back to plain lowest-index-first when none of those request.
  // NOTE: every always_comb output gets a default before any condition, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hi_req = '0;
    for (int p = 0; p < NPORT; p++) begin
      hi_req[p] = eligible_i[p] & (PTR_W'(p) >= ptr_i);
    end
    pick = (mode_i && (|hi_req)) ? hi_req : eligible_i;
    grant_o = '0;
    for (int p = NPORT - 1; p >= 0; p--) begin
      if (pick[p]) grant_o = NPORT'(1) << p;
    end
  end

endmodule

// File: rtl/mem_ctrl_nport.sv
// mem_ctrl_nport: arbitrates NPORT word requests onto one byte-wide RAM/IO bus,
// splitting 1..4-byte accesses into byte cycles and reassembling reads
// little-endian.
//   clk_in/rst_in/rdy_in : clock, sync active-high reset, global freeze (low)
//   req_*                : per-port request (level, held until req_ready)
//   flush_in             : abort this port's pending or in-flight read
//   req_ready            : one-hot combinational accept strobe
//   resp_valid/rdata     : registered completion pulse and shared read data
//   mem_*                : byte bus; mem_din arrives the cycle after mem_a
module mem_ctrl_nport
  import mem_ctrl_nport_pkg::*;
#(
  parameter int NPORT    = 2,
  parameter int ARB_MODE = 1,
  parameter int ADDR_W   = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [NPORT-1:0]        req_valid,
  input  logic [NPORT-1:0]        req_we,
  input  logic [2*NPORT-1:0]      req_len,
  input  logic [ADDR_W*NPORT-1:0] req_addr,
  input  logic [32*NPORT-1:0]     req_wdata,
  input  logic [NPORT-1:0]        flush_in,
  output logic [NPORT-1:0]        req_ready,
  output logic [NPORT-1:0]        resp_valid,
  output logic [31:0]             resp_rdata,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr
);

  localparam int PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1;

  mc_state_e         state_q, state_d;
  logic [PTR_W-1:0]  port_q, port_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  mem_len_t          len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [NPORT-1:0]  resp_valid_q, resp_valid_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;

  logic [NPORT-1:0]  eligible, grant;
  logic [PTR_W-1:0]  sel_port;
  logic              sel_we;
  mem_len_t          sel_len;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  // Accepts only happen from IDLE, never on a frozen or resetting edge.
  assign eligible = req_valid & ~flush_in
                  & {NPORT{rdy_in & ~rst_in & (state_q == MC_IDLE)}};

  rr_arbiter_n #(.NPORT(NPORT), .PTR_W(PTR_W)) u_arb (
    .eligible_i (eligible),
    .ptr_i      (rr_ptr_q),
    .mode_i     (ARB_MODE != 0),
    .grant_o    (grant)
  );

  assign req_ready  = grant;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  // A frozen cycle must not strobe the IO bus, or the held byte is written twice.
  assign mem_wr     = mem_wr_q & rdy_in & ~rst_in;

  always_comb begin
    sel_port  = '0;
    sel_we    = 1'b0;
    sel_len   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (grant[p]) begin
        sel_port  = PTR_W'(p);
        sel_we    = req_we[p];
        sel_len   = req_len[2*p +: 2];
        sel_addr  = req_addr[ADDR_W*p +: ADDR_W];
        sel_wdata = req_wdata[32*p +: 32];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    rr_ptr_d     = rr_ptr_q;
    len_d        = len_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    resp_valid_d = '0;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = 1'b0;

    unique case (state_q)
      MC_IDLE: begin
        if (|grant) begin
          state_d  = sel_we ? MC_WR : MC_RD;
          port_d   = sel_port;
          len_d    = sel_len;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          cnt_d    = '0;
          rdata_d  = '0;
          rr_ptr_d = (sel_port == PTR_W'(NPORT - 1)) ? '0 : sel_port + 1'b1;
        end
      end
      MC_RD: begin
        if (flush_in[port_q]) begin
          state_d = MC_IDLE;
        end else begin
          if (cnt_q <= {1'b0, len_q}) mem_a_d = addr_q + ADDR_W'(cnt_q);
          // Byte k appears two counter steps after it was addressed.
          if (cnt_q >= 3'd2) rdata_d[{cnt_q[1:0] - 2'd2, 3'b000} +: 8] = mem_din;
          if (cnt_q == last_cnt(len_q, 1'b1)) begin
            state_d              = MC_IDLE;
            resp_valid_d[port_q] = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      MC_WR: begin
        if (cnt_q <= {1'b0, len_q}) begin
          mem_a_d    = addr_q + ADDR_W'(cnt_q);
          mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
        end
        if (cnt_q == last_cnt(len_q, 1'b0)) begin
          state_d              = MC_IDLE;
          resp_valid_d[port_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = MC_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= MC_IDLE;
      port_q       <= '0;
      rr_ptr_q     <= '0;
      len_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      resp_valid_q <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      port_q       <= port_d;
      rr_ptr_q     <= rr_ptr_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl_nport.sv
// Directed bench for mem_ctrl_nport. A round-robin instance drives a byte RAM
// model and is scoreboarded; a fixed-priority twin shares the request inputs
// and is only watched for its grant pattern.
module tb_mem_ctrl_nport;
  import mem_ctrl_nport_pkg::*;

  localparam int NP = 2;

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b1;
  logic            rdy_in = 1'b1;
  logic [NP-1:0]   req_valid = '0;
  logic [NP-1:0]   req_we    = '0;
  logic [NP-1:0]   flush_in  = '0;
  logic [2*NP-1:0] req_len   = '0;
  logic [32*NP-1:0] req_addr  = '0;
  logic [32*NP-1:0] req_wdata = '0;

  logic [NP-1:0] req_ready, resp_valid;
  logic [31:0]   resp_rdata;
  logic [7:0]    mem_din, mem_dout;
  logic [31:0]   mem_a;
  logic          mem_wr;

  logic [NP-1:0] fx_req_ready, fx_resp_valid;
  logic [31:0]   fx_resp_rdata;
  logic [7:0]    fx_mem_din = 8'h00;
  logic [7:0]    fx_mem_dout;
  logic [31:0]   fx_mem_a;
  logic          fx_mem_wr;

  mem_ctrl_nport #(.NPORT(NP), .ARB_MODE(1), .ADDR_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .req_valid(req_valid), .req_we(req_we), .req_len(req_len),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush_in(flush_in),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  mem_ctrl_nport #(.NPORT(NP), .ARB_MODE(0), .ADDR_W(32)) dut_fx (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .req_valid(req_valid), .req_we(req_we), .req_len(req_len),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush_in(flush_in),
    .req_ready(fx_req_ready), .resp_valid(fx_resp_valid), .resp_rdata(fx_resp_rdata),
    .mem_din(fx_mem_din), .mem_dout(fx_mem_dout), .mem_a(fx_mem_a), .mem_wr(fx_mem_wr)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Synchronous byte RAM decoding the low 16 address bits (0x30000 aliases 0x0).
  logic [7:0]  ram [65536];
  logic [31:0] wlog [$];
  always @(posedge clk_in) begin
    if (mem_wr === 1'b1) begin
      ram[mem_a[15:0]] <= mem_dout;
      wlog.push_back(mem_a);
    end
    mem_din <= ram[mem_a[15:0]];
  end

  typedef struct {
    int          port;
    bit          rd;
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor: every resp_valid pulse must match the oldest expectation.
  always @(negedge clk_in) begin
    for (int p = 0; p < NP; p++) begin
      if (resp_valid[p] === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_resp", 32'(resp_valid), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_port", 32'(p), 32'(e.port));
          check("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
          if (e.rd) check("resp_rdata", resp_rdata, e.rdata);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic issue(input int p, input bit we, input logic [1:0] len,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit exp_resp, input int lat, input logic [31:0] exp_rdata);
    bit got;
    got = 1'b0;
    req_valid[p] = 1'b1;
    req_we[p] = we;
    req_len[2*p +: 2] = len;
    req_addr[32*p +: 32] = addr;
    req_wdata[32*p +: 32] = wdata;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (req_ready[p] === 1'b1) begin
        got = 1'b1;
        if (exp_resp) sb.push_back('{p, !we, exp_rdata, cyc + 1, lat});
      end
      @(negedge clk_in);
    end
    req_valid[p] = 1'b0;
    check("accept", 32'(got), 32'h1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk_in);
      #2;
    end
    check(tag, 32'(sb.size()), 32'h0);
    @(negedge clk_in);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_g [$];
    int fx0, fx1;
    fx0 = 0;
    fx1 = 0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'h11; ram[16'h0101] = 8'h22;
    ram[16'h0102] = 8'h33; ram[16'h0103] = 8'h44;
    ram[16'h0200] = 8'hAA; ram[16'h0201] = 8'hBB;
    ram[16'h0202] = 8'hCC; ram[16'h0203] = 8'hDD;
    ram[16'hFFFF] = 8'h5A;

    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // 1: port1 4-byte read, consecutive addresses, little-endian assembly
    issue(1, 1'b0, LEN_W, 32'h100, 32'h0, 1'b1, 6, 32'h44332211);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      check("t1_mem_a", mem_a, 32'h100 + k);
      check("t1_mem_wr", 32'(mem_wr), 32'h0);
    end
    drain("t1_drain");

    // 2: port0 2-byte write
    issue(0, 1'b1, LEN_H, 32'h30000, 32'h0000_4142, 1'b1, 3, 32'h0);
    check("t2_idle_wr", 32'(mem_wr), 32'h0);
    @(negedge clk_in);
    check("t2_wr0", 32'(mem_wr), 32'h1);
    check("t2_dout0", 32'(mem_dout), 32'h42);
    check("t2_a0", mem_a, 32'h30000);
    @(negedge clk_in);
    check("t2_wr1", 32'(mem_wr), 32'h1);
    check("t2_dout1", 32'(mem_dout), 32'h41);
    check("t2_a1", mem_a, 32'h30001);
    drain("t2_drain");
    check("t2_ram", {ram[16'h0001], ram[16'h0000]}, 32'h4142);

    // 3-byte read: upper byte zero; 2-byte read back of the write
    issue(0, 1'b0, 2'd2, 32'h200, 32'h0, 1'b1, 5, 32'h00CCBBAA);
    drain("t3b_drain");
    issue(1, 1'b0, LEN_H, 32'h30000, 32'h0, 1'b1, 4, 32'h0000_4142);
    drain("t2b_drain");

    // 3: both ports request continuously
    req_we = '0;
    req_len = '0;
    req_addr = {32'h101, 32'h100};
    req_valid = 2'b11;
    for (int i = 0; i < 21; i++) begin
      #1;
      if (req_ready[0] === 1'b1) begin
        rr_g.push_back(0);
        sb.push_back('{0, 1'b1, 32'h11, cyc + 1, 3});
      end
      if (req_ready[1] === 1'b1) begin
        rr_g.push_back(1);
        sb.push_back('{1, 1'b1, 32'h22, cyc + 1, 3});
      end
      if (fx_req_ready[0] === 1'b1) fx0++;
      if (fx_req_ready[1] === 1'b1) fx1++;
      @(negedge clk_in);
    end
    req_valid = '0;
    check("t3_rr_count", 32'(rr_g.size() >= 4), 32'h1);
    foreach (rr_g[i]) check("t3_rr_order", 32'(rr_g[i]), 32'(i % 2));
    check("t3_fx_port0", 32'(fx0 >= 4), 32'h1);
    check("t3_fx_port1", 32'(fx1), 32'h0);
    drain("t3_drain");

    // 4: flush port0 read in its 2nd RD cycle; port1 waiting
    issue(0, 1'b0, LEN_W, 32'h100, 32'h0, 1'b0, 0, 32'h0);
    req_valid[1] = 1'b1;
    req_we[1] = 1'b0;
    req_len[3:2] = LEN_B;
    req_addr[63:32] = 32'h102;
    @(negedge clk_in);
    flush_in[0] = 1'b1;
    #1;
    check("t4_busy_ready", 32'(req_ready), 32'h0);
    @(negedge clk_in);
    flush_in[0] = 1'b0;
    #1;
    check("t4_p1_ready", 32'(req_ready), 32'h2);
    check("t4_no_resp", 32'(resp_valid), 32'h0);
    if (req_ready[1] === 1'b1) sb.push_back('{1, 1'b1, 32'h33, cyc + 1, 3});
    @(negedge clk_in);
    req_valid[1] = 1'b0;
    drain("t4_drain");

    // 5: freeze 3 cycles mid 4-byte write
    wlog.delete();
    issue(0, 1'b1, LEN_W, 32'h400, 32'hDEADBEEF, 1'b1, 8, 32'h0);
    @(negedge clk_in);
    check("t5_wr_first", 32'(mem_wr), 32'h1);
    @(negedge clk_in);
    rdy_in = 1'b0;
    #1;
    check("t5_frz_wr0", 32'(mem_wr), 32'h0);
    @(negedge clk_in);
    check("t5_frz_wr1", 32'(mem_wr), 32'h0);
    @(negedge clk_in);
    check("t5_frz_wr2", 32'(mem_wr), 32'h0);
    check("t5_frz_a", mem_a, 32'h401);
    @(negedge clk_in);
    rdy_in = 1'b1;
    #1;
    check("t5_resume_wr", 32'(mem_wr), 32'h1);
    check("t5_resume_a", mem_a, 32'h401);
    drain("t5_drain");
    check("t5_wcount", 32'(wlog.size()), 32'h4);
    foreach (wlog[i]) check("t5_waddr", wlog[i], 32'h400 + i);
    check("t5_ram", {ram[16'h0403], ram[16'h0402], ram[16'h0401], ram[16'h0400]}, 32'hDEADBEEF);

    // 6: reset mid read, then reads at the top of the address space
    issue(1, 1'b0, LEN_W, 32'h100, 32'h0, 1'b0, 0, 32'h0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("t6_resp_valid", 32'(resp_valid), 32'h0);
    check("t6_rdata", resp_rdata, 32'h0);
    check("t6_mem_a", mem_a, 32'h0);
    check("t6_mem_dout", 32'(mem_dout), 32'h0);
    check("t6_mem_wr", 32'(mem_wr), 32'h0);
    rst_in = 1'b0;
    @(negedge clk_in);
    issue(0, 1'b0, LEN_B, 32'hFFFF_FFFF, 32'h0, 1'b1, 3, 32'h0000_005A);
    @(negedge clk_in);
    check("t6_top_a", mem_a, 32'hFFFF_FFFF);
    drain("t6_drain");
    issue(0, 1'b0, LEN_H, 32'hFFFF_FFFF, 32'h0, 1'b1, 4, 32'h0000_425A);
    @(negedge clk_in);
    check("t6_wrap_a0", mem_a, 32'hFFFF_FFFF);
    @(negedge clk_in);
    check("t6_wrap_a1", mem_a, 32'h0);
    drain("t6_wrap_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
